// File: rtl/ins_mem_loader.sv
// ============================================================================
// ins_mem_loader : byte-stream program loader, write side of instruction memory
// Optional checksum byte after the image: define INS_MEM_LOADER_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ins_mem_loader #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [CNT_W-1:0] words_written,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

`ifdef INS_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_CHK   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      asm_q, asm_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [7:0]       csum_q, csum_d;
  logic             acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    byte_ready = byte_ready || (state_q == S_CHK);
`endif
  end

  assign acc = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    err_d   = err_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (acc) begin
          idx_d  = '0;
          csum_d = '0;
          if (byte_in == 8'd0) begin
            state_d = S_DONE;
          end else if (int'(byte_in) > DEPTH) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            n_d     = byte_in[CNT_W-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Word and its address are captured together so both hold after the write.
            wdata_d = {byte_in, asm_q};
            addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
            state_d = S_WRITE;
          end else begin
            asm_d[{idx_q, 3'b000} +: 8] = byte_in;
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == n_q) begin
`ifdef INS_MEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (acc) begin
          if (byte_in != csum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we        = (state_q == S_WRITE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign words_written = cnt_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign cpu_hold      = (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
// ============================================================================
// tb_ins_mem_loader : scoreboard bench for ins_mem_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  words_written;
  logic        busy, done, err, cpu_hold;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        last_acc = 1'b0;
  logic [7:0]  csum;
  logic [7:0]  wb[4];

  always #5 clk = ~clk;

  ins_mem_loader #(.DEPTH(16), .BASE_ADDR(32'h0), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .words_written(words_written),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) last_acc <= byte_valid && byte_ready;

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("we_after_4th_byte", {63'd0, last_acc}, 64'd1);
      chk("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1;
    while (!byte_ready && t < 20) begin @(negedge clk); t++; end
    if (!byte_ready) chk("byte_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Sends one word, registering its expected write before the 4th byte.
  task automatic send_word(input logic [31:0] w, input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({a, w});
      send_byte(w[8*i +: 8]);
      csum ^= w[8*i +: 8];
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    @(negedge clk);
    chk(name, {63'd0, done}, 64'd1);
  endtask

  task automatic end_state(input string name, input logic e, input logic [4:0] n);
    chk({name, "_err"}, {63'd0, err}, {63'd0, e});
    chk({name, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_words"}, {59'd0, words_written}, {59'd0, n});
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, {63'd0, byte_ready}, 64'd0);
    chk({name, "_we"}, {63'd0, mem_we}, 64'd0);
    chk({name, "_addr_data"}, {mem_addr, mem_wdata}, 64'd0);
    chk({name, "_words"}, {59'd0, words_written}, 64'd0);
    chk({name, "_flags"}, {60'd0, busy, done, err, cpu_hold}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Two-word program.
    pulse_start();
    chk("busy_after_start", {62'd0, busy, cpu_hold}, 64'h3);
    csum = 8'h00;
    send_byte(8'h02);
    send_word(32'h2000_0013, 32'h0);
    send_word(32'h8C01_0022, 32'h4);
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    chk("csum_two_word", {56'd0, csum}, 64'h9C);
    send_byte(csum);
`endif
    wait_done("two_word_done");
    end_state("two_word", 1'b0, 5'd2);

    // Header above DEPTH.
    pulse_start();
    send_byte(8'h11);
    wait_done("over_depth_done");
    end_state("over_depth", 1'b1, 5'd0);

    // Empty program; also clears the previous err.
    pulse_start();
    send_byte(8'h00);
    wait_done("empty_done");
    end_state("empty", 1'b0, 5'd0);

    // Full-depth program with a start pulse mid-stream.
    pulse_start();
    csum = 8'h00;
    send_byte(8'h10);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) wb[i] = 8'((4*k + i) * 7 + 3);
      send_word({wb[3], wb[2], wb[1], wb[0]}, 32'(4*k));
      if (k == 5) pulse_start();
    end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    wait_done("full_done");
    end_state("full", 1'b0, 5'd16);

    // Reset in the middle of a 3-word load.
    pulse_start();
    csum = 8'h00;
    send_byte(8'h03);
    send_word(32'hDEAD_BEEF, 32'h0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    csum = 8'h00;
    send_byte(8'h01);
    send_word(32'h1234_5678, 32'h0);
`ifdef INS_MEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    wait_done("after_reset_done");
    end_state("after_reset", 1'b0, 5'd1);

`ifdef INS_MEM_LOADER_CHECKSUM_EN
    // Correct and wrong checksum for AA,55,0F,F0 (XOR = 00).
    pulse_start();
    send_byte(8'h01);
    send_word(32'hF00F_55AA, 32'h0);
    send_byte(8'h00);
    wait_done("csum_ok_done");
    end_state("csum_ok", 1'b0, 5'd1);
    pulse_start();
    send_byte(8'h01);
    send_word(32'hF00F_55AA, 32'h0);
    send_byte(8'h01);
    wait_done("csum_bad_done");
    end_state("csum_bad", 1'b1, 5'd1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Program loader: the write side of the instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and issues one-cycle word writes into the instruction store.
- Holds the CPU in reset while loading and releases it when the program image is complete.

Parameters:
- DEPTH, 16, number of 32-bit words in instruction memory; maximum program length.
- BASE_ADDR, 32'h00000000, byte address of word 0.
- CNT_W, 5, width of word counters; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte this cycle.
- mem_we  output  1  one-cycle word write strobe.
- mem_addr  output  32  byte address of write; BASE_ADDR + 4*index.
- mem_wdata  output  32  assembled instruction word.
- words_written  output  CNT_W  count of words written in the current load.
- busy  output  1  load in progress.
- done  output  1  load finished; sticky until next start.
- err  output  1  load aborted or corrupt; sticky until next start.
- cpu_hold  output  1  high holds CPU in reset; high from reset until done.

Behaviour:
- Reset (async, rst_n=0), all outputs:
  - state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - words_written=0, busy=0, done=0, err=0, cpu_hold=1.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready.
- byte_ready is a pure function of state: 1 in HDR and DATA, else 0.
- State machine:
  - IDLE: start -> HDR; busy=1.
  - HDR: accepted byte = word count N.
    - N=0 -> DONE, no writes.
    - N>DEPTH -> DONE with err=1, no writes.
    - Otherwise latch N, byte index=0 -> DATA.
  - DATA: bytes fill mem_wdata little-endian: byte0 to [7:0] … byte3 to [31:24]. 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=BASE_ADDR+4*words_written, mem_wdata=assembled word.
    - words_written increments at the end of the cycle.
    - If new count==N -> DONE (or CHK if the optional feature is compiled in); else -> DATA.
  - DONE: done=1, busy=0, cpu_hold=0. start -> clears done, err, words_written and goes to HDR (busy=1, cpu_hold=1 same edge).
- Timing and latency:
  - 4th byte accepted at edge t -> mem_we high for the cycle following t.
  - byte_ready low during that cycle, so throughput is at most 1 word per 5 cycles.
- start while busy is ignored.
- start and byte_valid in the same IDLE cycle: the byte is not accepted, since byte_ready=0.
- mem_we is never asserted outside WRITE.
- mem_addr and mem_wdata hold their last values otherwise.
- Reset mid-load: immediate return to the reset state. Partially assembled words are discarded, and a WRITE in progress is cut off by the reset.
- cpu_hold only falls at DONE entry, including error exits; a CPU fetch stays inhibited during any write.

Optional Feature:
- Macro: INS_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHK accepts one extra byte (byte_ready=1).
  - The byte must equal the XOR of all 4*N data bytes.
  - On mismatch: err=1. DONE is entered either way.
  - For N=0 no checksum byte is expected.
- Not defined: no CHK state; the last WRITE goes straight to DONE.

Test Plan:
- Reset then start; stream 02, 13,00,00,20, 22,00,01,8C -> two mem_we pulses:
  - addr 0x0, data 0x20000013;
  - addr 0x4, data 0x8C010022;
  - then done=1, cpu_hold=0, words_written=2, err=0.
- Header 0x11 (>DEPTH=16) -> no mem_we, err=1, done=1, cpu_hold=0.
- Header 0x00 -> done=1, err=0, words_written=0, no mem_we.
- Header 0x10 (=DEPTH), 64 data bytes with byte_valid toggling every other cycle -> 16 writes at addr 0x00..0x3C.
  - Each mem_we exactly one cycle after the 4th byte; byte_ready=0 during write cycles.
- Reset mid-load: assert rst_n=0 after header 03 and 6 data bytes -> outputs return to reset values immediately.
  - A fresh start with header 01, 78,56,34,12 writes 0x12345678 to 0x0.
- With INS_MEM_LOADER_CHECKSUM_EN: header 01, AA,55,0F,F0, checksum 00 -> err=0; checksum 01 -> err=1, done=1.
  - Pulse start while busy mid-stream -> ignored, byte sequence continues unaffected.
